// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester memory arbiter (instruction fetch = 0, data port = 1)
// in front of a single-port memory with a ready handshake and a WAIT timeout.
// Optional feature: define MEM_ARBITER_RR_EN for round-robin tie breaking;
// without it, requester 1 wins every tie.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [29:0] addr0,
  input  logic        req1,
  input  logic        we1,
  input  logic [29:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    ABORT
  } state_t;

  // Counter value seen in the last WAIT cycle before the transaction is abandoned.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] count;
  logic       grant;
  logic       winner;

  // A new transaction starts whenever anyone is asking while we are idle.
  always_comb begin
    grant = (state == IDLE) && (req0 || req1);
  end

`ifdef MEM_ARBITER_RR_EN
  logic last_owner;

  // On a tie, hand the bus to whoever did not get it last time.
  always_comb begin
    if (req0 && req1) winner = ~last_owner;
    else              winner = req1;
  end

  // Remember the most recent grant so ties alternate.
  always_ff @(posedge clk) begin
    if (reset)      last_owner <= 1'b1;
    else if (grant) last_owner <= winner;
  end
`else
  // Data port always beats instruction fetch; a lone request still wins.
  always_comb begin
    winner = req1;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; a ready response beats the timeout in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req0 || req1) next_state = WAIT;
      end
      WAIT: begin
        if (mem_ready)                next_state = RESP;
        else if (count == LAST_COUNT) next_state = ABORT;
      end
      RESP:    next_state = IDLE;
      ABORT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the winner's operands at grant, count WAIT cycles, capture read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= 1'b0;
      count     <= 8'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 30'd0;
      mem_wdata <= 32'd0;
      rdata     <= 32'd0;
    end else begin
      if (grant) begin
        owner     <= winner;
        count     <= 8'd0;
        mem_addr  <= winner ? addr1 : addr0;
        mem_we    <= winner ? we1 : 1'b0;
        mem_wdata <= winner ? wdata1 : 32'd0;
      end
      if (state == WAIT) begin
        count <= count + 8'd1;
        if (mem_ready) rdata <= mem_rdata;
      end
    end
  end

  // Decode handshake and status outputs from the current state and owner.
  always_comb begin
    busy    = (state != IDLE);
    mem_req = (state == WAIT);
    ack0    = (state == RESP)  && !owner;
    ack1    = (state == RESP)  &&  owner;
    err0    = (state == ABORT) && !owner;
    err1    = (state == ABORT) &&  owner;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, hand-written corner sequences and a
// randomized run against a transaction-level reference model of mem_arbiter.
module tb_mem_arbiter;

  localparam int TIMEOUT = 15;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, req0, req1, we1, mem_ready;
  logic [29:0] addr0, addr1;
  logic [31:0] wdata1, mem_rdata;
  logic        ack0, ack1, err0, err1, mem_req, mem_we, busy, owner;
  logic [29:0] mem_addr;
  logic [31:0] rdata, mem_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    logic        rst, r0, r1, we, rdy;
    logic [29:0] a0, a1;
    logic [31:0] wd, mrd;
    logic        e_ack0, e_ack1, e_err0, e_err1, e_mreq, e_busy, e_owner, e_we;
    logic [29:0] e_addr;
    logic [31:0] e_wdata, e_rdata;
  } vec_t;

  vec_t tbl[$];

  // Reference model: one transaction at a time, described by whether it is
  // in flight, how many memory-wait cycles it has used, and how it finished.
  bit          m_active;
  int          m_done;
  int          m_waited;
  logic        m_owner, m_last, m_we;
  logic [29:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ea0, input logic ea1, input logic ee0,
                          input logic ee1, input logic emr, input logic ebz, input logic eow,
                          input logic ewe, input logic [29:0] ead, input logic [31:0] ewd,
                          input logic [31:0] erd);
    checkOutput({tag, ".ack0"},      32'(ack0),      32'(ea0));
    checkOutput({tag, ".ack1"},      32'(ack1),      32'(ea1));
    checkOutput({tag, ".err0"},      32'(err0),      32'(ee0));
    checkOutput({tag, ".err1"},      32'(err1),      32'(ee1));
    checkOutput({tag, ".mem_req"},   32'(mem_req),   32'(emr));
    checkOutput({tag, ".busy"},      32'(busy),      32'(ebz));
    checkOutput({tag, ".owner"},     32'(owner),     32'(eow));
    checkOutput({tag, ".mem_we"},    32'(mem_we),    32'(ewe));
    checkOutput({tag, ".mem_addr"},  32'(mem_addr),  32'(ead));
    checkOutput({tag, ".mem_wdata"}, mem_wdata,      ewd);
    checkOutput({tag, ".rdata"},     rdata,          erd);
  endtask

  // One clock cycle: compare mid-cycle, then step past the next rising edge.
  task automatic cycle(input string tag, input logic ea0, input logic ea1, input logic ee0,
                       input logic ee1, input logic emr, input logic ebz, input logic eow,
                       input logic ewe, input logic [29:0] ead, input logic [31:0] ewd,
                       input logic [31:0] erd);
    @(negedge clk);
    checkAll(tag, ea0, ea1, ee0, ee1, emr, ebz, eow, ewe, ead, ewd, erd);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    reset = v.rst; req0 = v.r0; req1 = v.r1; we1 = v.we; mem_ready = v.rdy;
    addr0 = v.a0; addr1 = v.a1; wdata1 = v.wd; mem_rdata = v.mrd;
  endtask

  task automatic addRow(input logic rst, input logic r0, input logic r1, input logic we,
                        input logic [29:0] a0, input logic [29:0] a1, input logic [31:0] wd,
                        input logic rdy, input logic [31:0] mrd,
                        input logic ea0, input logic ea1, input logic ee0, input logic ee1,
                        input logic emr, input logic ebz, input logic eow, input logic ewe,
                        input logic [29:0] ead, input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.we = we; v.a0 = a0; v.a1 = a1; v.wd = wd;
    v.rdy = rdy; v.mrd = mrd;
    v.e_ack0 = ea0; v.e_ack1 = ea1; v.e_err0 = ee0; v.e_err1 = ee1; v.e_mreq = emr;
    v.e_busy = ebz; v.e_owner = eow; v.e_we = ewe; v.e_addr = ead; v.e_wdata = ewd;
    v.e_rdata = erd;
    tbl.push_back(v);
  endtask

  task automatic modelReset();
    m_active = 1'b0; m_done = 0; m_waited = 0; m_owner = 1'b0; m_last = 1'b1;
    m_we = 1'b0; m_addr = 30'd0; m_wdata = 32'd0; m_rdata = 32'd0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    logic w;
    if (reset) begin
      modelReset();
    end else if (!m_active) begin
      if (req0 || req1) begin
        if (req0 && req1) w = RR ? !m_last : 1'b1;
        else              w = req1;
        m_last = w; m_owner = w; m_active = 1'b1; m_done = 0; m_waited = 0;
        m_addr = w ? addr1 : addr0;
        m_we = w ? we1 : 1'b0;
        m_wdata = w ? wdata1 : 32'd0;
      end
    end else if (m_done != 0) begin
      m_active = 1'b0;
      m_done = 0;
    end else begin
      m_waited++;
      if (mem_ready) begin
        m_rdata = mem_rdata;
        m_done = 1;
      end else if (m_waited == TIMEOUT) begin
        m_done = 2;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        prev_owner, w, p0, p1;
    logic [29:0] prev_addr, h_addr;
    logic [31:0] prev_wd, prev_rd, d, h_wd, h_rd;
    logic        h_owner, h_we;
    logic        e_a0, e_a1, e_e0, e_e1;

    // Build the directed table: a single load, then four contended loads.
    addRow(0, 0, 1, 0, 0, 30'h10, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    addRow(0, 0, 1, 0, 0, 30'h10, 0, 1, 32'hDEADBEEF,  0, 0, 0, 0, 1, 1, 1, 0, 30'h10, 0, 0);
    addRow(0, 0, 1, 0, 0, 30'h10, 0, 0, 0,             0, 1, 0, 0, 0, 1, 1, 0, 30'h10, 0, 32'hDEADBEEF);
    addRow(0, 0, 0, 0, 0, 30'h10, 0, 0, 0,             0, 0, 0, 0, 0, 0, 1, 0, 30'h10, 0, 32'hDEADBEEF);
    prev_owner = 1'b1; prev_addr = 30'h10; prev_wd = 32'd0; prev_rd = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      w = RR ? 1'(k % 2) : 1'b1;
      d = 32'hA000_0000 + 32'(k);
      addRow(0, 1, 1, 0, 30'h100, 30'h200, 32'h5555, 0, 0,
             0, 0, 0, 0, 0, 0, prev_owner, 0, prev_addr, prev_wd, prev_rd);
      prev_owner = w; prev_addr = w ? 30'h200 : 30'h100; prev_wd = w ? 32'h5555 : 32'd0;
      addRow(0, 1, 1, 0, 30'h100, 30'h200, 32'h5555, 1, d,
             0, 0, 0, 0, 1, 1, w, 0, prev_addr, prev_wd, prev_rd);
      prev_rd = d;
      addRow(0, 1, 1, 0, 30'h100, 30'h200, 32'h5555, 0, 0,
             !w, w, 0, 0, 0, 1, w, 0, prev_addr, prev_wd, prev_rd);
    end
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, prev_owner, 0, prev_addr, prev_wd, prev_rd);

    // Reset state.
    reset = 1; req0 = 0; req1 = 0; we1 = 0; mem_ready = 0;
    addr0 = 0; addr1 = 0; wdata1 = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkAll($sformatf("tbl%0d", i), tbl[i].e_ack0, tbl[i].e_ack1, tbl[i].e_err0,
               tbl[i].e_err1, tbl[i].e_mreq, tbl[i].e_busy, tbl[i].e_owner, tbl[i].e_we,
               tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_rdata);
      @(posedge clk);
      #1;
    end
    h_owner = prev_owner; h_addr = prev_addr; h_wd = prev_wd; h_we = 1'b0; h_rd = prev_rd;

    // Memory never answers: exactly TIMEOUT wait cycles, then err0.
    req0 = 1; addr0 = 30'h55; req1 = 0; mem_ready = 0;
    cycle("toIdle", 0, 0, 0, 0, 0, 0, h_owner, h_we, h_addr, h_wd, h_rd);
    h_owner = 0; h_addr = 30'h55; h_wd = 0; h_we = 0;
    for (int i = 1; i <= TIMEOUT; i++)
      cycle($sformatf("toWait%0d", i), 0, 0, 0, 0, 1, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    cycle("toErr", 0, 0, 1, 0, 0, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    req0 = 0; mem_ready = 1; mem_rdata = 32'hBAD;
    cycle("toIdle2", 0, 0, 0, 0, 0, 0, h_owner, h_we, h_addr, h_wd, h_rd);
    mem_ready = 0;

    // Memory answers in the last allowed wait cycle: ack wins.
    req1 = 1; we1 = 0; addr1 = 30'h77; wdata1 = 0;
    cycle("nearIdle", 0, 0, 0, 0, 0, 0, h_owner, h_we, h_addr, h_wd, h_rd);
    h_owner = 1; h_addr = 30'h77; h_wd = 0; h_we = 0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      if (i == TIMEOUT) begin
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
      end
      cycle($sformatf("nearWait%0d", i), 0, 0, 0, 0, 1, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    end
    mem_ready = 0; h_rd = 32'hCAFEF00D;
    cycle("nearAck", 0, 1, 0, 0, 0, 1, h_owner, h_we, h_addr, h_wd, h_rd);

    // Store with a three-cycle memory, then a repeat cut short by reset.
    we1 = 1; wdata1 = 32'h12345678; addr1 = 30'h3;
    cycle("stIdle", 0, 0, 0, 0, 0, 0, h_owner, h_we, h_addr, h_wd, h_rd);
    h_we = 1; h_addr = 30'h3; h_wd = 32'h12345678;
    cycle("stWait1", 0, 0, 0, 0, 1, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    cycle("stWait2", 0, 0, 0, 0, 1, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    mem_ready = 1; mem_rdata = 32'h0BADC0DE;
    cycle("stWait3", 0, 0, 0, 0, 1, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    mem_ready = 0; h_rd = 32'h0BADC0DE;
    cycle("stAck", 0, 1, 0, 0, 0, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    cycle("stIdle2", 0, 0, 0, 0, 0, 0, h_owner, h_we, h_addr, h_wd, h_rd);
    cycle("stWait1b", 0, 0, 0, 0, 1, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    reset = 1;
    cycle("stWait2b", 0, 0, 0, 0, 1, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    reset = 0;
    cycle("rstState", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    h_rd = 0;
    req1 = 0;
    cycle("postRstWait1", 0, 0, 0, 0, 1, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    mem_ready = 1; mem_rdata = 32'h600D;
    cycle("postRstWait2", 0, 0, 0, 0, 1, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    mem_ready = 0; h_rd = 32'h600D;
    cycle("dropAck", 0, 1, 0, 0, 0, 1, h_owner, h_we, h_addr, h_wd, h_rd);
    cycle("dropIdle", 0, 0, 0, 0, 0, 0, h_owner, h_we, h_addr, h_wd, h_rd);

    // Randomized traffic checked against the reference model.
    reset = 1; req0 = 0; req1 = 0; mem_ready = 0;
    @(posedge clk);
    modelReset();
    #1;
    reset = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      e_a0 = m_active && (m_done == 1) && !m_owner;
      e_a1 = m_active && (m_done == 1) &&  m_owner;
      e_e0 = m_active && (m_done == 2) && !m_owner;
      e_e1 = m_active && (m_done == 2) &&  m_owner;
      checkAll($sformatf("rnd%0d", cyc), e_a0, e_a1, e_e0, e_e1, m_active && (m_done == 0),
               m_active, m_owner, m_we, m_addr, m_wdata, m_rdata);
      p0 = e_a0 || e_e0;
      p1 = e_a1 || e_e1;
      @(posedge clk);
      modelEdge();
      #1;
      if (!req0 || p0) begin
        req0 = ($urandom_range(0, 2) == 0);
        addr0 = 30'($urandom);
      end else if ($urandom_range(0, 63) == 0) begin
        req0 = 0;
      end
      if (!req1 || p1) begin
        req1 = ($urandom_range(0, 2) == 0);
        we1 = 1'($urandom);
        addr1 = 30'($urandom);
        wdata1 = $urandom;
      end else if ($urandom_range(0, 63) == 0) begin
        req1 = 0;
      end
      if (((cyc / 250) % 4) == 3) mem_ready = ($urandom_range(0, 39) == 0);
      else                        mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      reset = ($urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum WAIT cycles without mem_ready before abort; legal range 1..255.
REQ-002 clk  in  1  rising-edge clock; the only clock.
REQ-003 reset  in  1  reset, synchronous and active-high.
REQ-004 req0  in  1  requester 0 (instruction fetch) request; read-only, level.
REQ-005 addr0  in  30 [31:2]  requester 0 word address.
REQ-006 req1  in  1  requester 1 (data port) request, level.
REQ-007 we1  in  1  requester 1 write enable (1=store, 0=load).
REQ-008 addr1  in  30 [31:2]  requester 1 word address.
REQ-009 wdata1  in  32  requester 1 store data.
REQ-010 ack0, ack1  out  1 each  one-cycle completion pulse for the owning requester.
REQ-011 err0, err1  out  1 each  one-cycle timeout-abort pulse for the owning requester.
REQ-012 rdata  out  32  shared read data; valid in the ack cycle.
REQ-013 mem_req  out  1  memory request; mem_we  out  1; mem_addr  out  30 [31:2]; mem_wdata  out  32.
REQ-014 mem_rdata  in  32  memory read data; mem_ready  in  1  memory completion.
REQ-015 busy  out  1  transaction in flight; owner  out  1  index of the current or last granted requester.

Function
REQ-016 States SHALL be IDLE, WAIT, RESP and ABORT; busy=1 in every state except IDLE.
REQ-017 Requests SHALL be sampled only in IDLE; each requester holds req and its operands stable until it sees ack or err.
REQ-018 IDLE with any req: pick a winner per REQ-030/031; latch addr, we and wdata (requester 0: we=0, wdata=0); owner<=winner; counter<=0; next state WAIT.
REQ-019 WAIT: mem_req=1 and mem_we/mem_addr/mem_wdata driven from the latched registers; counter +1 per cycle.
REQ-020 WAIT with mem_ready=1: rdata<=mem_rdata (loads and stores alike); next state RESP.
REQ-021 WAIT with mem_ready=0 and counter==TIMEOUT-1: next state ABORT; mem_ready in the same cycle takes precedence over the timeout.
REQ-022 RESP: mem_req=0; ack[owner]=1 for exactly one cycle; next state IDLE.
REQ-023 ABORT: mem_req=0; err[owner]=1 for exactly one cycle; rdata unchanged; next state IDLE.
REQ-024 Minimum latency: req high in IDLE at cycle n, mem_req high at n+1; mem_ready at n+1 gives ack at n+2.
REQ-025 Minimum spacing: one transaction per 3 cycles (WAIT, RESP, IDLE).
REQ-026 mem_ready outside WAIT SHALL be ignored.
REQ-027 If req drops mid-transaction, the transaction SHALL complete and ack/err SHALL still pulse.
REQ-028 At most one of ack0, ack1, err0, err1 SHALL be high in any cycle; the non-owner never receives a pulse.
REQ-029 mem_addr, mem_we and mem_wdata SHALL hold their last latched values outside WAIT.

Configuration
REQ-030 With macro MEM_ARBITER_RR_EN defined: round-robin; on a tie in IDLE, grant the requester not granted last (last_owner register, updated at each grant).
REQ-031 Without MEM_ARBITER_RR_EN: fixed priority; requester 1 wins every tie; no last_owner register.
REQ-032 In both modes a lone request SHALL always be granted.

Reset
REQ-033 reset=1 at a clock edge SHALL force state IDLE, counter 0, rdata 0, owner 0, all ack/err/mem_req/mem_we/busy 0, mem_addr 0, mem_wdata 0, last_owner 1.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no ack or err; mem_req is low from the first cycle after the reset edge.
REQ-035 Requests SHALL be evaluated in the first IDLE cycle after reset deasserts.

Verification
REQ-036 req1=1, we1=0, addr1=0x10; memory ready after 1 cycle with mem_rdata=0xDEADBEEF -> mem_req at n+1, ack1 at n+2, rdata=0xDEADBEEF.
REQ-037 req0 and req1 both held for 4 transactions -> RR: grants 0,1,0,1; non-RR: grants 1,1,1,1.
REQ-038 mem_ready never asserted, TIMEOUT=15 -> exactly 15 WAIT cycles, then one err pulse to the owner, then IDLE, busy=0.
REQ-039 mem_ready asserted in the 15th WAIT cycle (TIMEOUT=15) -> ack, no err.
REQ-040 Store req1=1, we1=1, wdata1=0x12345678, memory ready after 3 cycles -> mem_we=1 and mem_wdata=0x12345678 throughout WAIT; reset asserted during WAIT on a repeat transaction -> no ack, mem_req=0 next cycle, all outputs 0.
